mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage data-memory controller of the 5-stage MIPS pipeline, between the EX/MEM register and the MEM/WB register.
//  Turns lw/lh/lhu/lb/lbu/sw/sh/sb into handshaked transactions on a word-wide data bus.
//  Stalls upstream stages while a transaction is outstanding and hands MEM/WB the ALU result, formatted load data and WB controls.
// PARAMETERS
//  TIMEOUT  16  max BUSY cycles without dmem_ack before abort (>=1)
//  CNT_W    5   width of timeout counter (2^CNT_W > TIMEOUT)
// PORTS
//  clk             in   1   clock, rising edge
//  rst             in   1   reset, synchronous, active-high
//  mem_read        in   1   load in MEM stage
//  mem_write       in   1   store in MEM stage
//  mem_size        in   2   00 byte, 01 half, 10 word, 11 illegal
//  mem_signed      in   1   1: sign-extend byte/half loads (lb/lh)
//  alu_result      in   32  effective address / non-memory result
//  store_data      in   32  rt value for stores, right-aligned
//  ctrl_wb_in      in   2   WB controls {reg_write, mem_to_reg}
//  reg_dst_in      in   5   destination register
//  alu_result_out  out  32  alu_result passthrough to MEM/WB
//  mem_data_out    out  32  formatted load data to MEM/WB
//  ctrl_wb_out     out  2   WB controls to MEM/WB (2'b00 = bubble)
//  reg_dst_out     out  5   reg_dst_in passthrough
//  stall           out  1   hold PC, IF/ID, ID/EX, EX/MEM this cycle
//  mem_fault       out  1   1-cycle pulse: misaligned/illegal or timeout
//  dmem_req        out  1   bus request, registered
//  dmem_we         out  1   1 write, 0 read
//  dmem_addr       out  32  word address {alu_result[31:2],2'b00}
//  dmem_wdata      out  32  lane-replicated store data
//  dmem_be         out  4   byte enables, bit i = byte lane i
//  dmem_rdata      in   32  read data, valid with dmem_ack
//  dmem_ack        in   1   transaction complete
// BEHAVIOUR
//  Reset: state IDLE; dmem_req/we=0, dmem_addr/wdata=0, dmem_be=0, load register=0, timeout counter=0, mem_fault=0.
//  Non-memory op (mem_read=mem_write=0): pure passthrough, stall=0, mem_data_out = load register (don't-care).
//  Little-endian. Byte lane = addr[1:0]; half lane = addr[1].
//   Byte: be=4'b0001<<addr[1:0], wdata={4{sd[7:0]}}. Half: be=4'b0011<<{addr[1],1'b0}, wdata={2{sd[15:0]}}.
//   Word: be=4'b1111, wdata=sd. Loads: select lane, then zero-/sign-extend per mem_signed.
//  Illegal: half with addr[0]=1; word with addr[1:0]!=0; size=11; mem_read&mem_write.
//   No bus request issued; mem_fault=1 for that cycle; ctrl_wb_out=00; stall=0; state stays IDLE.
//  FSM IDLE -> BUSY -> DONE -> IDLE:
//   IDLE: legal access -> stall=1, ctrl_wb_out=00; on edge latch dmem_* signals, dmem_req<=1, counter<=0, go BUSY.
//   BUSY: stall=1, ctrl_wb_out=00; dmem_req and all dmem_* held stable.
//    ack=1 -> dmem_req<=0; load register<=formatted rdata (loads only); go DONE.
//    ack=0 -> counter++; counter==TIMEOUT-1 -> dmem_req<=0, go DONE with fault flag set.
//   DONE: stall=0; ctrl_wb_out=ctrl_wb_in (00 if fault flag); mem_data_out=load register; mem_fault=fault flag; go IDLE.
//  Latency: ack in first BUSY cycle -> stall high 2 cycles, MEM/WB captures at end of 3rd cycle.
//  Upstream holds all inputs stable while stall=1. Store data never reaches mem_data_out.
//  dmem_ack is ignored outside BUSY. An ack that coincides with the timeout edge counts as success.
//  rst in any state -> IDLE next edge: dmem_req drops, no fault pulse, in-flight ack ignored.
// TESTING
//  lw addr 0x10, ack after 1 BUSY cycle, rdata 0xDEADBEEF -> stall 2 cycles, be=1111, mem_data_out=0xDEADBEEF, ctrl_wb passed in DONE.
//  lb addr 0x13, rdata 0x80FF_0000 -> mem_data_out=0xFFFFFF80. Same access as lbu -> 0x00000080.
//  sh addr 0x22, store_data 0x1234ABCD -> dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_we=1, addr 0x20.
//  lw addr 0x06 -> no dmem_req, mem_fault pulse, ctrl_wb_out=00, stall=0.
//  lw with no ack, TIMEOUT=4 -> dmem_req high 4 cycles, then DONE with mem_fault=1, ctrl_wb_out=00.
//  rst asserted in BUSY, ack next cycle -> IDLE, dmem_req=0, no fault, load register=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory controller: turns loads/stores into one handshaked
// word-bus transaction, stalls upstream while it is in flight and hands the
// MEM/WB register the ALU result, formatted load data and WB controls.
module mem_access_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_signed,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [1:0]  ctrl_wb_in,
  input  logic [4:0]  reg_dst_in,
  output logic [31:0] alu_result_out,
  output logic [31:0] mem_data_out,
  output logic [1:0]  ctrl_wb_out,
  output logic [4:0]  reg_dst_out,
  output logic        stall,
  output logic        mem_fault,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              fault_flag;
  logic [31:0]       load_reg;
  logic              is_mem, illegal, legal, timeout_hit;
  logic [3:0]        be_calc;
  logic [31:0]       wdata_calc, shifted, load_fmt;

  assign alu_result_out = alu_result;
  assign reg_dst_out    = reg_dst_in;
  assign mem_data_out   = load_reg;
  assign timeout_hit    = (cnt == CNT_W'(TIMEOUT - 1));

  // Decode legality, byte enables, lane-replicated store data and load formatting.
  // Inputs are held stable while stalled, so the live address/size drive the
  // load formatter during BUSY as well.
  always_comb begin
    is_mem  = mem_read | mem_write;
    illegal = is_mem && ((mem_read && mem_write) || (mem_size == 2'b11) ||
                         (mem_size == 2'b01 && alu_result[0]) ||
                         (mem_size == 2'b10 && alu_result[1:0] != 2'b00));
    legal   = is_mem && !illegal;
    be_calc    = 4'b0000;
    wdata_calc = store_data;
    case (mem_size)
      2'b00: begin
        be_calc    = 4'b0001 << alu_result[1:0];
        wdata_calc = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_calc    = 4'b0011 << {alu_result[1], 1'b0};
        wdata_calc = {2{store_data[15:0]}};
      end
      2'b10:   be_calc = 4'b1111;
      default: be_calc = 4'b0000;
    endcase
    // a half access is aligned, so {addr[1:0],3'b0} is also the half-lane shift
    shifted = dmem_rdata >> {alu_result[1:0], 3'b000};
    case (mem_size)
      2'b00:   load_fmt = {{24{mem_signed & shifted[7]}},  shifted[7:0]};
      2'b01:   load_fmt = {{16{mem_signed & shifted[15]}}, shifted[15:0]};
      default: load_fmt = dmem_rdata;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, stall, WB-control gating and fault pulse.
  always_comb begin
    state_nxt   = state;
    stall       = 1'b0;
    ctrl_wb_out = ctrl_wb_in;
    mem_fault   = 1'b0;
    case (state)
      IDLE: begin
        if (illegal) begin
          ctrl_wb_out = 2'b00;
          mem_fault   = 1'b1;
        end else if (legal) begin
          stall       = 1'b1;
          ctrl_wb_out = 2'b00;
          state_nxt   = BUSY;
        end
      end
      BUSY: begin
        stall       = 1'b1;
        ctrl_wb_out = 2'b00;
        if (dmem_ack || timeout_hit) state_nxt = DONE;
      end
      DONE: begin
        ctrl_wb_out = fault_flag ? 2'b00 : ctrl_wb_in;
        mem_fault   = fault_flag;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus request registers, timeout counter, fault flag and load register.
  // An ack on the timeout cycle wins over the abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
      load_reg   <= '0;
      cnt        <= '0;
      fault_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (legal) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write;
            dmem_addr  <= {alu_result[31:2], 2'b00};
            dmem_wdata <= wdata_calc;
            dmem_be    <= be_calc;
            cnt        <= '0;
            fault_flag <= 1'b0;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (!dmem_we) load_reg <= load_fmt;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (timeout_hit) begin
              dmem_req   <= 1'b0;
              fault_flag <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboarded random bench for mem_access_unit: a driver issues operations
// and pushes expected MEM/WB and bus results, a bus responder checks requests
// and acks after a chosen delay, and a monitor checks each unstalled output.
module tb_mem_access_unit;
  localparam int T = 4;

  logic        clk, rst;
  logic        mem_read, mem_write, mem_signed;
  logic [1:0]  mem_size, ctrl_wb_in, ctrl_wb_out;
  logic [31:0] alu_result, store_data, alu_result_out, mem_data_out;
  logic [4:0]  reg_dst_in, reg_dst_out;
  logic        stall, mem_fault, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  mem_access_unit #(.TIMEOUT(T), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .mem_signed(mem_signed), .alu_result(alu_result),
    .store_data(store_data), .ctrl_wb_in(ctrl_wb_in), .reg_dst_in(reg_dst_in),
    .alu_result_out(alu_result_out), .mem_data_out(mem_data_out),
    .ctrl_wb_out(ctrl_wb_out), .reg_dst_out(reg_dst_out), .stall(stall),
    .mem_fault(mem_fault), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack));

  initial begin clk = 0; forever #5 clk = ~clk; end

  typedef struct {
    logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata;
    int d; logic [31:0] rdata;
  } bus_t;
  typedef struct {
    logic [1:0] ctrl; logic [4:0] rd; logic [31:0] alu; logic fault; logic [31:0] data;
  } exp_t;

  bus_t bq[$];
  exp_t eq[$];
  int   checks = 0, passed = 0;
  bit   mon_en = 0, resp_en = 0;
  logic [31:0] ld_model = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Reference model of one operation, then drive it and hold until consumed.
  task automatic issue(input logic rd_, input logic wr_, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] rdata, input int d);
    exp_t e; bus_t b;
    int nb, n, exp_stall;
    logic legal, ok;
    logic [31:0] v, mask;
    logic [1:0] cw;
    logic [4:0] rdst;
    cw = 2'($urandom); rdst = 5'($urandom);
    nb = 1 << sz;
    legal = (rd_ | wr_) && !(rd_ && wr_) && sz != 2'd3 && (a % nb) == 0;
    ok = legal && d <= T - 1;
    e.fault = (rd_ | wr_) && !ok;
    e.ctrl  = e.fault ? 2'b00 : cw;
    e.rd = rdst; e.alu = a;
    if (legal) begin
      b.addr = a & ~32'd3;
      b.be = 4'(((1 << nb) - 1) << (a % 4));
      b.we = wr_;
      for (int i = 0; i < 4; i++) b.wdata[8*i +: 8] = sd[8*(i % nb) +: 8];
      b.d = d; b.rdata = rdata;
      bq.push_back(b);
      if (ok && rd_) begin
        v = rdata >> (8 * (a % 4));
        if (nb < 4) begin
          mask = (32'h1 << (8 * nb)) - 1;
          v = v & mask;
          if (sg && v[8*nb-1]) v = v | ~mask;
        end
        ld_model = v;
      end
    end
    e.data = ld_model;
    eq.push_back(e);
    mem_read = rd_; mem_write = wr_; mem_size = sz; mem_signed = sg;
    alu_result = a; store_data = sd; ctrl_wb_in = cw; reg_dst_in = rdst;
    exp_stall = legal ? ((d + 1 < T ? d + 1 : T) + 1) : 0;
    n = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      n++;
      if (n > 50) begin
        $display("FAIL stall_timeout: got %0d stall cycles want %0d", n, exp_stall);
        $fatal(1);
      end
    end
    chk("stall_cycles", n, exp_stall);
    @(posedge clk); #1;
  endtask

  // Bus responder: checks request fields, acks after the chosen delay.
  bus_t cur;
  bit   in_txn = 0;
  int   k = 0;
  initial begin
    dmem_ack = 0; dmem_rdata = 0;
    forever begin
      @(negedge clk);
      if (resp_en) begin
        if (dmem_req) begin
          if (!in_txn) begin
            in_txn = 1; k = 0;
            if (bq.size() == 0) begin
              checks++;
              $display("FAIL unexpected_req: got addr %h want no request", dmem_addr);
              cur.d = T + 1; cur.rdata = 0; cur.we = 0;
            end else begin
              cur = bq.pop_front();
              chk("dmem_addr", dmem_addr, cur.addr);
              chk("dmem_be", 32'(dmem_be), 32'(cur.be));
              chk("dmem_we", 32'(dmem_we), 32'(cur.we));
              if (cur.we) chk("dmem_wdata", dmem_wdata, cur.wdata);
            end
          end
          dmem_ack = (k == cur.d);
          dmem_rdata = dmem_ack ? cur.rdata : $urandom;
          k++;
        end else begin
          if (in_txn) begin
            in_txn = 0;
            chk("req_cycles", k, (cur.d + 1 < T) ? cur.d + 1 : T);
          end
          dmem_ack = 1'($urandom);   // stray acks outside BUSY must be ignored
          dmem_rdata = $urandom;
        end
      end
    end
  end

  // Monitor: every unstalled cycle presents one completed operation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && !stall) begin
        if (eq.size() == 0) begin
          checks++;
          $display("FAIL scoreboard_empty: got output ctrl %b want none", ctrl_wb_out);
        end else begin
          e = eq.pop_front();
          chk("ctrl_wb_out", 32'(ctrl_wb_out), 32'(e.ctrl));
          chk("reg_dst_out", 32'(reg_dst_out), 32'(e.rd));
          chk("alu_result_out", alu_result_out, e.alu);
          chk("mem_fault", 32'(mem_fault), 32'(e.fault));
          chk("mem_data_out", mem_data_out, e.data);
        end
      end
    end
  end

  initial begin
    int kind;
    logic rd_, wr_;
    logic [1:0] sz;
    rst = 1; mem_read = 0; mem_write = 0; mem_size = 0; mem_signed = 0;
    alu_result = 0; store_data = 0; ctrl_wb_in = 0; reg_dst_in = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(dmem_req), 0);
    chk("rst_we", 32'(dmem_we), 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_be", 32'(dmem_be), 0);
    chk("rst_fault", 32'(mem_fault), 0);
    chk("rst_load", mem_data_out, 0);
    @(posedge clk); #1; rst = 0;
    resp_en = 1; mon_en = 1;

    issue(1, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    issue(1, 0, 2'b00, 1, 32'h13, 32'h0, 32'h80FF0000, 1);
    issue(1, 0, 2'b00, 0, 32'h13, 32'h0, 32'h80FF0000, 2);
    issue(0, 1, 2'b01, 0, 32'h22, 32'h1234ABCD, 32'h0, 0);
    issue(1, 0, 2'b10, 0, 32'h06, 32'h0, 32'h0, 0);
    issue(1, 0, 2'b10, 0, 32'h40, 32'h0, 32'h11111111, T + 3);
    issue(1, 0, 2'b01, 1, 32'h42, 32'h0, 32'h8001_7FFF, T - 1);
    issue(1, 1, 2'b10, 0, 32'h50, 32'h0, 32'h0, 0);
    issue(1, 0, 2'b11, 0, 32'h50, 32'h0, 32'h0, 0);
    issue(0, 0, 2'b10, 0, 32'h77, 32'h55, 32'h0, 0);

    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 9);
      rd_ = 0; wr_ = 0;
      if (kind >= 2) begin
        rd_ = 1'($urandom); wr_ = !rd_;
        if (kind == 9) begin rd_ = 1; wr_ = 1; end
      end
      sz = ($urandom_range(0, 7) < 7) ? 2'($urandom_range(0, 2)) : 2'b11;
      issue(rd_, wr_, sz, 1'($urandom), $urandom, $urandom, $urandom,
            $urandom_range(0, T + 1));
    end

    // reset while BUSY with an ack arriving on the reset edge
    issue(1, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    mon_en = 0; resp_en = 0; dmem_ack = 0;
    mem_read = 1; mem_write = 0; mem_size = 2'b10; alu_result = 32'h10;
    @(posedge clk); #1;
    chk("busy_req", 32'(dmem_req), 1);
    rst = 1; dmem_ack = 1; dmem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    rst = 0; dmem_ack = 0; mem_read = 0;
    @(negedge clk);
    chk("rstbusy_req", 32'(dmem_req), 0);
    chk("rstbusy_fault", 32'(mem_fault), 0);
    chk("rstbusy_load", mem_data_out, 0);
    chk("rstbusy_stall", 32'(stall), 0);
    @(negedge clk);
    chk("rstbusy_req2", 32'(dmem_req), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
